// File: rtl/sdram_rd_burst.sv
// sdram_rd_burst: SDRAM read engine, splits bursts at column-page ends
// with linear col->row->bank carry; returns data with a per-beat ack.
// Ports: sys_clk, sys_rst_n (async, active-low), init_end,
//   rd_en/addr/rd_burst_len (request), rd_sdram_data (DQ in),
//   rd_cmd/rd_ba/rd_addr (to arbiter), rd_data/rd_ack (beats),
//   rd_end (done pulse), rd_busy (accept through rd_end).
module sdram_rd_burst #(
  parameter int BA_W    = 2,
  parameter int ROW_W   = 13,
  parameter int COL_W   = 9,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10,
  parameter int CAS_LAT = 3,
  parameter int TRCD    = 2,
  parameter int TRP     = 2
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         init_end,
  input  logic                         rd_en,
  input  logic [BA_W+ROW_W+COL_W-1:0]  addr,
  input  logic [LEN_W-1:0]             rd_burst_len,
  input  logic [DATA_W-1:0]            rd_sdram_data,
  output logic [3:0]                   rd_cmd,
  output logic [BA_W-1:0]              rd_ba,
  output logic [ROW_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_ack,
  output logic                         rd_end,
  output logic                         rd_busy
);
  localparam int AW = BA_W + ROW_W + COL_W;
  localparam int CW = COL_W + 4;
  localparam int SW = (LEN_W > COL_W + 1) ? LEN_W : COL_W + 1;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_BST = 4'b0110;
  localparam logic [3:0] C_PRE = 4'b0010;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACT  = 3'd1;
  localparam logic [2:0] S_TRCD = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_PRE  = 3'd5;
  localparam logic [2:0] S_TRP  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    cur_q, cur_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [COL_W:0]   seg_q, seg_d;

  logic [BA_W-1:0]  cur_ba;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  assign {cur_ba, cur_row, cur_col} = cur_q;

  // Words left in the open page versus words left in the request.
  logic [SW-1:0] room, rem_x, seg_x;
  assign room  = (SW'(1) << COL_W) - SW'(cur_col);
  assign rem_x = SW'(remain_q);
  assign seg_x = (rem_x < room) ? rem_x : room;

  // cnt_q counts cycles since READ while in DATA.
  logic beat_end;
  logic [2:0] nxt;
  assign beat_end = cnt_q == CW'(CAS_LAT) + CW'(seg_q) - CW'(1);
  assign nxt      = (remain_q != '0) ? S_ACT : S_DONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    remain_d = remain_q;
    seg_d    = seg_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd_en && init_end && rd_burst_len != '0) begin
          cur_d    = addr;
          remain_d = rd_burst_len;
          state_d  = S_ACT;
        end
      end
      S_ACT: begin
        cnt_d   = CW'(1);
        state_d = (TRCD == 1) ? S_RD : S_TRCD;
      end
      S_TRCD: begin
        if (cnt_q == CW'(TRCD - 1)) state_d = S_RD;
        else cnt_d = cnt_q + CW'(1);
      end
      S_RD: begin
        // Advance now; the DATA/PRE tail only needs seg_q.
        seg_d    = seg_x[COL_W:0];
        remain_d = remain_q - LEN_W'(seg_x);
        cur_d    = cur_q + AW'(seg_x);
        cnt_d    = CW'(1);
        state_d  = S_DATA;
      end
      S_DATA: begin
        if (beat_end) state_d = S_PRE;
        else cnt_d = cnt_q + CW'(1);
      end
      S_PRE: begin
        cnt_d   = CW'(1);
        state_d = (TRP == 1) ? nxt : S_TRP;
      end
      S_TRP: begin
        if (cnt_q == CW'(TRP - 1)) state_d = nxt;
        else cnt_d = cnt_q + CW'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cur_q    <= '0;
      remain_q <= '0;
      seg_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      remain_q <= remain_d;
      seg_q    <= seg_d;
    end
  end

  logic [ROW_W-1:0] col_a;
  always_comb begin
    col_a     = ROW_W'(cur_col);
    col_a[10] = 1'b0;
    rd_cmd    = C_NOP;
    rd_ba     = '0;
    rd_addr   = '0;
    unique case (state_q)
      S_ACT: begin
        rd_cmd  = C_ACT;
        rd_ba   = cur_ba;
        rd_addr = cur_row;
      end
      S_RD: begin
        rd_cmd  = C_RD;
        rd_ba   = cur_ba;
        rd_addr = col_a;
      end
      S_DATA: begin
        if (cnt_q == CW'(seg_q)) rd_cmd = C_BST;
      end
      S_PRE: begin
        rd_cmd      = C_PRE;
        rd_addr[10] = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_ack  = (state_q == S_DATA) && (cnt_q >= CW'(CAS_LAT));
  assign rd_data = rd_ack ? rd_sdram_data : '0;
  assign rd_end  = state_q == S_DONE;
  assign rd_busy = state_q != S_IDLE;
endmodule

// File: tb/tb_sdram_rd_burst.sv
// tb_sdram_rd_burst: scoreboard bench for sdram_rd_burst, default
// geometry instance plus a CAS2/TRCD3/COL8/DQ32 instance.
`timescale 1ns/1ps
module tb_sdram_rd_burst;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, init_end;
  logic        rd_en1, rd_en2;
  logic [23:0] addr1;
  logic [22:0] addr2;
  logic [9:0]  len1, len2;
  logic [31:0] dqw;
  logic [3:0]  cmd1, cmd2;
  logic [1:0]  ba1, ba2;
  logic [12:0] ra1, ra2;
  logic [15:0] data1;
  logic [31:0] data2;
  logic        ack1, ack2, end1, end2, busy1, busy2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int acks1 = 0, ends1 = 0, acks2 = 0, ends2 = 0;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic       chk_ba;
    logic [1:0] ba;
    logic [12:0] addr;
    logic [12:0] mask;
  } ev_t;
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } ak_t;

  ev_t qc1[$], qc2[$];
  ak_t qa1[$], qa2[$];

  function automatic logic [31:0] dqv(input int c);
    return 32'(c) * 32'h9E3779B1 + 32'h1234_5678;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  assign dqw = dqv(cyc);

  sdram_rd_burst u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .init_end(init_end),
    .rd_en(rd_en1), .addr(addr1), .rd_burst_len(len1),
    .rd_sdram_data(dqw[15:0]),
    .rd_cmd(cmd1), .rd_ba(ba1), .rd_addr(ra1),
    .rd_data(data1), .rd_ack(ack1), .rd_end(end1), .rd_busy(busy1)
  );

  sdram_rd_burst #(.CAS_LAT(2), .TRCD(3), .COL_W(8), .DATA_W(32)) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .init_end(init_end),
    .rd_en(rd_en2), .addr(addr2), .rd_burst_len(len2),
    .rd_sdram_data(dqw),
    .rd_cmd(cmd2), .rd_ba(ba2), .rd_addr(ra2),
    .rd_data(data2), .rd_ack(ack2), .rd_end(end2), .rd_busy(busy2)
  );

  always @(negedge clk) begin
    ev_t e;
    ak_t k;
    if (cmd1 != 4'b0111) begin
      checks++;
      if (qc1.size() == 0) begin
        errors++;
        $display("FAIL d1_cmd_unexpected cyc=%0d got=%b", cyc, cmd1);
      end else begin
        e = qc1.pop_front();
        if (e.cyc !== cyc || e.cmd !== cmd1 ||
            (e.chk_ba && e.ba !== ba1) ||
            (ra1 & e.mask) !== (e.addr & e.mask)) begin
          errors++;
          $display("FAIL d1_cmd cyc=%0d got=%b/%0d/%h want cyc=%0d %b/%0d/%h",
                   cyc, cmd1, ba1, ra1, e.cyc, e.cmd, e.ba, e.addr);
        end
      end
    end
    if (end1) begin
      ends1++;
      checks++;
      if (qc1.size() == 0) begin
        errors++;
        $display("FAIL d1_end_unexpected cyc=%0d", cyc);
      end else begin
        e = qc1.pop_front();
        if (e.cyc !== cyc || e.cmd !== 4'hF) begin
          errors++;
          $display("FAIL d1_end cyc=%0d want cyc=%0d cmd=%b", cyc, e.cyc, e.cmd);
        end
      end
    end
    checks++;
    if (ack1) begin
      acks1++;
      if (qa1.size() == 0) begin
        errors++;
        $display("FAIL d1_ack_unexpected cyc=%0d", cyc);
      end else begin
        k = qa1.pop_front();
        if (k.cyc !== cyc || data1 !== k.data[15:0]) begin
          errors++;
          $display("FAIL d1_ack cyc=%0d data=%h want cyc=%0d data=%h",
                   cyc, data1, k.cyc, k.data[15:0]);
        end
      end
    end else if (data1 !== 16'h0) begin
      errors++;
      $display("FAIL d1_data_gate cyc=%0d got=%h want=0", cyc, data1);
    end
  end

  always @(negedge clk) begin
    ev_t e;
    ak_t k;
    if (cmd2 != 4'b0111) begin
      checks++;
      if (qc2.size() == 0) begin
        errors++;
        $display("FAIL d2_cmd_unexpected cyc=%0d got=%b", cyc, cmd2);
      end else begin
        e = qc2.pop_front();
        if (e.cyc !== cyc || e.cmd !== cmd2 ||
            (e.chk_ba && e.ba !== ba2) ||
            (ra2 & e.mask) !== (e.addr & e.mask)) begin
          errors++;
          $display("FAIL d2_cmd cyc=%0d got=%b/%0d/%h want cyc=%0d %b/%0d/%h",
                   cyc, cmd2, ba2, ra2, e.cyc, e.cmd, e.ba, e.addr);
        end
      end
    end
    if (end2) begin
      ends2++;
      checks++;
      if (qc2.size() == 0) begin
        errors++;
        $display("FAIL d2_end_unexpected cyc=%0d", cyc);
      end else begin
        e = qc2.pop_front();
        if (e.cyc !== cyc || e.cmd !== 4'hF) begin
          errors++;
          $display("FAIL d2_end cyc=%0d want cyc=%0d cmd=%b", cyc, e.cyc, e.cmd);
        end
      end
    end
    checks++;
    if (ack2) begin
      acks2++;
      if (qa2.size() == 0) begin
        errors++;
        $display("FAIL d2_ack_unexpected cyc=%0d", cyc);
      end else begin
        k = qa2.pop_front();
        if (k.cyc !== cyc || data2 !== k.data) begin
          errors++;
          $display("FAIL d2_ack cyc=%0d data=%h want cyc=%0d data=%h",
                   cyc, data2, k.cyc, k.data);
        end
      end
    end else if (data2 !== 32'h0) begin
      errors++;
      $display("FAIL d2_data_gate cyc=%0d got=%h want=0", cyc, data2);
    end
  end

  // Reference model: expected command/ack timeline for one request.
  task automatic model(input int dut, input int t0,
                       input logic [31:0] a0, input int n0);
    int cas, trcd, trp, cw, aw, t, col, room, seg, n;
    logic [31:0] a;
    ev_t e;
    ak_t k;
    if (dut == 1) begin
      cas = 3; trcd = 2; trp = 2; cw = 9; aw = 24;
    end else begin
      cas = 2; trcd = 3; trp = 2; cw = 8; aw = 23;
    end
    a = a0;
    n = n0;
    t = t0 + 1;
    while (n > 0) begin
      col  = int'(a & ((32'd1 << cw) - 32'd1));
      room = (1 << cw) - col;
      seg  = (n < room) ? n : room;
      e.cyc = t; e.cmd = 4'b0011; e.chk_ba = 1'b1;
      e.ba = 2'(a >> (cw + 13)); e.addr = 13'(a >> cw); e.mask = '1;
      if (dut == 1) qc1.push_back(e); else qc2.push_back(e);
      e.cyc = t + trcd; e.cmd = 4'b0101; e.addr = 13'(col);
      if (dut == 1) qc1.push_back(e); else qc2.push_back(e);
      e.cyc = t + trcd + seg; e.cmd = 4'b0110; e.chk_ba = 1'b0;
      e.mask = '0;
      if (dut == 1) qc1.push_back(e); else qc2.push_back(e);
      for (int i = 0; i < seg; i++) begin
        k.cyc  = t + trcd + cas + i;
        k.data = dqv(k.cyc);
        if (dut == 1) qa1.push_back(k); else qa2.push_back(k);
      end
      e.cyc = t + trcd + cas + seg; e.cmd = 4'b0010;
      e.addr = 13'h400; e.mask = 13'h400;
      if (dut == 1) qc1.push_back(e); else qc2.push_back(e);
      t = t + trcd + cas + seg + trp;
      a = (a + 32'(seg)) & ((32'd1 << aw) - 32'd1);
      n = n - seg;
    end
    e.cyc = t; e.cmd = 4'hF; e.chk_ba = 1'b0; e.mask = '0;
    if (dut == 1) qc1.push_back(e); else qc2.push_back(e);
  endtask

  task automatic req(input int dut, input logic [31:0] a, input int n);
    @(posedge clk); #1;
    if (dut == 1) begin
      rd_en1 = 1'b1; addr1 = 24'(a); len1 = 10'(n);
    end else begin
      rd_en2 = 1'b1; addr2 = 23'(a); len2 = 10'(n);
    end
    model(dut, cyc, a, n);
    @(posedge clk); #1;
    rd_en1 = 1'b0;
    rd_en2 = 1'b0;
  endtask

  task automatic wait_done(input int dut, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (dut == 1 ? (qc1.size() + qa1.size() == 0)
                   : (qc2.size() + qa2.size() == 0)) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d/%0d want 0", nm,
               qc1.size() + qa1.size(), qc2.size() + qa2.size());
      qc1.delete(); qa1.delete(); qc2.delete(); qa2.delete();
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ((dut == 1 ? busy1 : busy2) !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after got=1 want=0", nm);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; init_end = 1'b0;
    rd_en1 = 1'b0; rd_en2 = 1'b0;
    addr1 = '0; addr2 = '0; len1 = '0; len2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd1 !== 4'b0111 || cmd2 !== 4'b0111) begin
      errors++;
      $display("FAIL rst_cmd got=%b/%b want=0111", cmd1, cmd2);
    end
    checks++;
    if (ba1 !== 2'd0 || ra1 !== 13'd0 || data1 !== 16'd0) begin
      errors++;
      $display("FAIL rst_bus got=%0d/%h/%h want=0", ba1, ra1, data1);
    end
    checks++;
    if ({ack1, end1, busy1, ack2, end2, busy2} !== 6'b0) begin
      errors++;
      $display("FAIL rst_flags got=%b want=0",
               {ack1, end1, busy1, ack2, end2, busy2});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_end = 1'b1;
  endtask

  task automatic test_single;
    int a0, e0;
    a0 = acks1; e0 = ends1;
    req(1, 32'h000010, 8);
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got=%b want=1", busy1);
    end
    wait_done(1, "single");
    checks++;
    if (acks1 - a0 != 8 || ends1 - e0 != 1) begin
      errors++;
      $display("FAIL single_count acks=%0d ends=%0d want 8/1",
               acks1 - a0, ends1 - e0);
    end
  endtask

  task automatic test_page_cross;
    int a0, e0;
    a0 = acks1; e0 = ends1;
    req(1, 32'h0001FC, 8);
    wait_done(1, "cross");
    checks++;
    if (acks1 - a0 != 8 || ends1 - e0 != 1) begin
      errors++;
      $display("FAIL cross_count acks=%0d ends=%0d want 8/1",
               acks1 - a0, ends1 - e0);
    end
  endtask

  task automatic test_wrap;
    int a0, e0;
    a0 = acks1; e0 = ends1;
    req(1, 32'h3FFFFE, 4);
    wait_done(1, "bank_carry");
    req(1, 32'hFFFFFF, 2);
    wait_done(1, "wrap");
    checks++;
    if (acks1 - a0 != 6 || ends1 - e0 != 2) begin
      errors++;
      $display("FAIL wrap_count acks=%0d ends=%0d want 6/2",
               acks1 - a0, ends1 - e0);
    end
  endtask

  task automatic test_drop;
    int a0, e0;
    a0 = acks1; e0 = ends1;
    init_end = 1'b0;
    @(posedge clk); #1;
    rd_en1 = 1'b1; addr1 = 24'h000010; len1 = 10'd8;
    repeat (3) @(posedge clk); #1;
    rd_en1 = 1'b0; init_end = 1'b1;
    @(posedge clk); #1;
    rd_en1 = 1'b1; len1 = 10'd0;
    repeat (3) @(posedge clk); #1;
    rd_en1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0) begin
        errors++;
        $display("FAIL drop_busy cyc=%0d got=%b want=0", cyc, busy1);
      end
    end
    checks++;
    if (acks1 != a0 || ends1 != e0) begin
      errors++;
      $display("FAIL drop_count acks=%0d ends=%0d want 0/0",
               acks1 - a0, ends1 - e0);
    end
  endtask

  task automatic test_ignore_busy;
    int a0, e0;
    a0 = acks1; e0 = ends1;
    req(1, 32'h000040, 8);
    repeat (2) @(posedge clk); #1;
    rd_en1 = 1'b1; addr1 = 24'h123456; len1 = 10'd5;
    repeat (4) @(posedge clk); #1;
    rd_en1 = 1'b0;
    wait_done(1, "ignore");
    checks++;
    if (acks1 - a0 != 8 || ends1 - e0 != 1) begin
      errors++;
      $display("FAIL ignore_count acks=%0d ends=%0d want 8/1",
               acks1 - a0, ends1 - e0);
    end
  endtask

  task automatic test_async_reset;
    int a0, e0;
    bit seen;
    a0 = acks1;
    seen = 1'b0;
    req(1, 32'h000100, 16);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (acks1 != a0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL arst_no_ack got=0 acks want>0");
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd1 !== 4'b0111 || ack1 !== 1'b0 || busy1 !== 1'b0 ||
        data1 !== 16'h0 || end1 !== 1'b0) begin
      errors++;
      $display("FAIL arst_out got cmd=%b ack=%b busy=%b data=%h want 0111/0/0/0",
               cmd1, ack1, busy1, data1);
    end
    qc1.delete();
    qa1.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    a0 = acks1; e0 = ends1;
    req(1, 32'h000200, 4);
    wait_done(1, "arst_after");
    checks++;
    if (acks1 - a0 != 4 || ends1 - e0 != 1) begin
      errors++;
      $display("FAIL arst_count acks=%0d ends=%0d want 4/1",
               acks1 - a0, ends1 - e0);
    end
  endtask

  task automatic test_sweep;
    int a0, e0;
    a0 = acks2; e0 = ends2;
    req(2, 32'h0, 300);
    wait_done(2, "sweep");
    checks++;
    if (acks2 - a0 != 300 || ends2 - e0 != 1) begin
      errors++;
      $display("FAIL sweep_count acks=%0d ends=%0d want 300/1",
               acks2 - a0, ends2 - e0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_page_cross();
    test_wrap();
    test_drop();
    test_ignore_busy();
    test_async_reset();
    test_sweep();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
